instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch stage of the 19-bit-ISA core, and the initiator on the instruction-memory read port.
- Holds the PC and drives the memory address. Captures the returned 19-bit instruction into the IF/ID register.
- Handles stalls, branch/jump redirects from execute, and the all-zero end-of-program marker.
- Sits between instructionMemory (combinational read) and decode.

Parameters:
- ADDR_W, 12, PC / instruction-memory address width.
- INSTR_W, 19, instruction width.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept; hold PC and IF/ID.
- redirect_valid  in  1  execute resolved a taken branch or a jump this cycle.
- redirect_is_jump  in  1  1 = jump (absolute), 0 = branch (PC-relative).
- redirect_pc  in  ADDR_W  PC of the redirecting instruction.
- redirect_imm  in  ADDR_W  jump: absolute target; branch: imm8 in bits [7:0].
- imem_address  out  ADDR_W  address to instruction memory.
- imem_instruction  in  INSTR_W  instruction word returned by memory in the same cycle.
- if_id_instruction  out  INSTR_W  registered instruction to decode.
- if_id_pc  out  ADDR_W  PC of if_id_instruction.
- if_id_valid  out  1  if_id_instruction is real (not a bubble).
- halted  out  1  unit is in HALT.
- fetch_count  out  CNT_W  instructions delivered since reset, saturating.

Behaviour:
- Clocking: one clock, `clock`. Reset is synchronous and active-high on `reset`; all state updates on the rising edge of `clock`.
- Reset (dominates all inputs):
  - pc=0, state=RUN.
  - if_id_instruction=0, if_id_pc=0, if_id_valid=0.
  - halted=0, fetch_count=0.
  - imem_address=0 in the following cycle.
- imem_address = pc, combinational. Memory latency is 0, so the instruction is sampled in the same cycle.
- States: RUN and HALT; halted = (state==HALT).
- Per-cycle priority: reset > redirect > stall > halt-detect > normal.
- Redirect (either state, overrides stall):
  - pc <= target; if_id_valid <= 0; if_id_instruction <= 0; state <= RUN.
  - Jump target = redirect_imm.
  - Branch target = redirect_pc + 1 + sign_extend(redirect_imm[7:0]), modulo 2^ADDR_W.
  - Exactly one bubble per redirect. The current fetch is discarded and not counted.
- Stall (RUN, no redirect): pc, IF/ID, state and fetch_count all hold.
- Halt-detect (RUN, no stall/redirect, imem_instruction == 0):
  - pc holds; if_id_valid <= 0; if_id_instruction <= 0; state <= HALT.
  - The marker is not delivered and not counted.
- Normal (RUN):
  - if_id_instruction <= imem_instruction; if_id_pc <= pc; if_id_valid <= 1; pc <= pc+1.
  - fetch_count <= fetch_count+1, saturating at all-ones.
- HALT:
  - pc holds; if_id_valid <= 0; stall is ignored.
  - Exits only via redirect (halt word was on a wrong path) or reset.
- Wrap-around: pc 4095 increments to 0; branch targets wrap the same way.
- Simultaneous stall+redirect: redirect wins and the bubble is written even though stall is high.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, INSTR_W, HALT_WORD = 19'b0.
  - Opcode prefixes (R=2'b00, I=2'b01, MEM=3'b100, BR=3'b101, JMP=5'b11100), for decode reuse.
  - fetch_state_t enum {RUN, HALT}.
- One combinational sub-module, branch_target_calc: (redirect_is_jump, redirect_pc, redirect_imm) -> target. Reused by execute for misprediction checks.

Test Plan:
- Reset, then memory 0..3 = nonzero words, no stall:
  - imem_address 0,1,2,3 on consecutive cycles.
  - if_id_pc 0,1,2 with valid=1 starting one cycle after reset release.
  - fetch_count increments each cycle.
- Stall high 3 cycles at pc=2:
  - imem_address stays 2; IF/ID holds pc=1 word; fetch_count frozen.
  - Resumes at pc 3 on deassert.
- Branch redirects:
  - redirect_pc=6, imm=8'd1, branch -> next imem_address=8, one bubble (valid=0).
  - redirect_pc=9, imm=8'hF8 -> target 2.
  - Jump imm=12'd2 -> target 2.
- Word at address 10 = 0 -> halted=1, pc stays 10, valid=0, fetch_count excludes it.
  - Later redirect (jump to 2) -> RUN, imem_address=2.
- Boundaries:
  - pc=4095 normal fetch -> next pc=0.
  - stall and redirect in same cycle -> redirect taken and bubble inserted.
  - reset asserted mid-run with stall high -> pc=0, valid=0, fetch_count=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit-ISA core: widths, halt marker,
// opcode prefixes (for decode) and the fetch state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  // An all-zero word marks the end of the program.
  localparam logic [INSTR_W-1:0] HALT_WORD = '0;

  // Opcode prefixes, left-aligned in the instruction word.
  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_I   = 2'b01;
  localparam logic [2:0] OP_MEM = 3'b100;
  localparam logic [2:0] OP_BR  = 3'b101;
  localparam logic [4:0] OP_JMP = 5'b11100;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Redirect target: a jump goes to the absolute immediate; a branch goes to
// pc+1 plus the sign-extended low byte of the immediate. The sum wraps
// modulo 2^ADDR_W. Execute reuses this for misprediction checks.
module branch_target_calc #(
  parameter int ADDR_W = 12
) (
  input  logic              redirect_is_jump_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic [ADDR_W-1:0] redirect_imm_i,
  output logic [ADDR_W-1:0] target_o
);

  logic [ADDR_W-1:0] imm8_sext;

  // Widen imm8 to the address width so the add wraps naturally.
  always_comb begin
    imm8_sext = {{(ADDR_W-8){redirect_imm_i[7]}}, redirect_imm_i[7:0]};
    if (redirect_is_jump_i)
      target_o = redirect_imm_i;
    else
      target_o = redirect_pc_i + ADDR_W'(1) + imm8_sext;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// loads the IF/ID register. Priority per cycle is
// reset > redirect > stall > halt-detect > normal fetch.
module instruction_fetch_unit #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic               redirect_is_jump,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [ADDR_W-1:0]  redirect_imm,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);
  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               vld_q, vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  redirect_target;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_btc (
    .redirect_is_jump_i (redirect_is_jump),
    .redirect_pc_i      (redirect_pc),
    .redirect_imm_i     (redirect_imm),
    .target_o           (redirect_target)
  );

  // Zero-latency memory: the word for pc comes back in the same cycle.
  assign imem_address      = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc          = ifpc_q;
  assign if_id_valid       = vld_q;
  assign halted            = (state_q == HALT);
  assign fetch_count       = cnt_q;

  // Next-state: everything holds unless a higher-priority event applies.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      // Current fetch is on the wrong path: drop it and insert one bubble,
      // even while decode is stalled, and leave HALT if we were there.
      pc_d    = redirect_target;
      vld_d   = 1'b0;
      instr_d = '0;
      state_d = RUN;
    end else if (state_q == HALT) begin
      vld_d = 1'b0;
    end else if (stall) begin
      // Decode is busy: freeze PC, IF/ID and the counter.
    end else if (imem_instruction == INSTR_W'(HALT_WORD)) begin
      // End marker is neither delivered nor counted; pc parks on it.
      vld_d   = 1'b0;
      instr_d = '0;
      state_d = HALT;
    end else begin
      instr_d = imem_instruction;
      ifpc_d  = pc_q;
      vld_d   = 1'b1;
      pc_d    = pc_q + ADDR_W'(1);
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      instr_q <= '0;
      ifpc_q  <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a directed vector table walking the
// fetch/stall/redirect/halt/wrap scenarios, then randomized traffic checked
// against an abstract model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam int AW = 12;
  localparam int IW = 19;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset, stall, redirect_valid, redirect_is_jump;
  logic [AW-1:0] redirect_pc, redirect_imm;
  logic [AW-1:0] imem_address;
  logic [IW-1:0] imem_instruction;
  logic [IW-1:0] if_id_instruction;
  logic [AW-1:0] if_id_pc;
  logic          if_id_valid, halted;
  logic [CW-1:0] fetch_count;

  logic [IW-1:0] mem [0:4095];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  assign imem_instruction = mem[imem_address];

  instruction_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_is_jump  (redirect_is_jump),
    .redirect_pc       (redirect_pc),
    .redirect_imm      (redirect_imm),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid),
    .halted            (halted),
    .fetch_count       (fetch_count)
  );

  typedef struct {
    bit      rst, stl, rv, rj;
    int      rpc, rimm;
    int      e_addr, e_ifpc, e_cnt;
    bit      e_vld, e_halt;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Apply one cycle of inputs: drive on the falling edge, sample 1 time unit
  // after the rising edge.
  task automatic cycle(input bit rst, input bit stl, input bit rv, input bit rj,
                       input int rpc, input int rimm);
    @(negedge clock);
    reset = rst; stall = stl; redirect_valid = rv; redirect_is_jump = rj;
    redirect_pc = AW'(rpc); redirect_imm = AW'(rimm);
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t v(bit rst, bit stl, bit rv, bit rj, int rpc, int rimm,
                             int ea, bit ev, int eifpc, bit eh, int ec);
    vec_t r;
    r.rst = rst; r.stl = stl; r.rv = rv; r.rj = rj; r.rpc = rpc; r.rimm = rimm;
    r.e_addr = ea; r.e_vld = ev; r.e_ifpc = eifpc; r.e_halt = eh; r.e_cnt = ec;
    return r;
  endfunction

  function automatic int word_at(int a);
    return (a == 10) ? 0 : ('h100 + a);
  endfunction

  // Reference model state, in plain integers.
  int  m_pc, m_ifpc, m_cnt, m_instr;
  bit  m_vld, m_halt;

  task automatic model_step(input bit rst, input bit stl, input bit rv, input bit rj,
                            input int rpc, input int rimm);
    int off;
    if (rst) begin
      m_pc = 0; m_ifpc = 0; m_cnt = 0; m_instr = 0; m_vld = 0; m_halt = 0;
    end else if (rv) begin
      if (rj) m_pc = rimm % 4096;
      else begin
        off = rimm % 256;
        if (off >= 128) off -= 256;
        m_pc = (rpc + 1 + off + 4096) % 4096;
      end
      m_vld = 0; m_instr = 0; m_halt = 0;
    end else if (m_halt) begin
      m_vld = 0;
    end else if (stl) begin
      // nothing moves
    end else if (int'(mem[m_pc]) == 0) begin
      m_halt = 1; m_vld = 0; m_instr = 0;
    end else begin
      m_instr = int'(mem[m_pc]);
      m_ifpc  = m_pc;
      m_vld   = 1;
      m_pc    = (m_pc + 1) % 4096;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_is_jump = 1'b0;
    redirect_pc = '0; redirect_imm = '0;
    for (int a = 0; a < 4096; a++) mem[a] = IW'(word_at(a));

    //        rst stl rv rj rpc   rimm   addr vld ifpc halt cnt
    vt.push_back(v(1,0,0,0, 0,    0,     0,   0, 0,    0, 0));  // reset
    vt.push_back(v(0,0,0,0, 0,    0,     1,   1, 0,    0, 1));
    vt.push_back(v(0,0,0,0, 0,    0,     2,   1, 1,    0, 2));
    vt.push_back(v(0,1,0,0, 0,    0,     2,   1, 1,    0, 2));  // stall x3
    vt.push_back(v(0,1,0,0, 0,    0,     2,   1, 1,    0, 2));
    vt.push_back(v(0,1,0,0, 0,    0,     2,   1, 1,    0, 2));
    vt.push_back(v(0,0,0,0, 0,    0,     3,   1, 2,    0, 3));
    vt.push_back(v(0,0,0,0, 0,    0,     4,   1, 3,    0, 4));
    vt.push_back(v(0,0,0,0, 0,    0,     5,   1, 4,    0, 5));
    vt.push_back(v(0,0,0,0, 0,    0,     6,   1, 5,    0, 6));
    vt.push_back(v(0,0,1,0, 6,    1,     8,   0, 5,    0, 6));  // br +1
    vt.push_back(v(0,0,0,0, 0,    0,     9,   1, 8,    0, 7));
    vt.push_back(v(0,0,1,0, 9,    'hF8,  2,   0, 8,    0, 7));  // br -8
    vt.push_back(v(0,0,0,0, 0,    0,     3,   1, 2,    0, 8));
    vt.push_back(v(0,0,1,1, 0,    2,     2,   0, 2,    0, 8));  // jump 2
    vt.push_back(v(0,0,1,1, 0,    9,     9,   0, 2,    0, 8));  // jump 9
    vt.push_back(v(0,0,0,0, 0,    0,     10,  1, 9,    0, 9));
    vt.push_back(v(0,0,0,0, 0,    0,     10,  0, 9,    1, 9));  // halt word
    vt.push_back(v(0,1,0,0, 0,    0,     10,  0, 9,    1, 9));  // stall ignored
    vt.push_back(v(0,0,0,0, 0,    0,     10,  0, 9,    1, 9));
    vt.push_back(v(0,0,1,1, 0,    2,     2,   0, 9,    0, 9));  // leave halt
    vt.push_back(v(0,0,0,0, 0,    0,     3,   1, 2,    0, 10));
    vt.push_back(v(0,1,1,1, 0,    4095,  4095,0, 2,    0, 10)); // stall+redirect
    vt.push_back(v(0,0,0,0, 0,    0,     0,   1, 4095, 0, 11)); // pc wrap
    vt.push_back(v(0,0,0,0, 0,    0,     1,   1, 0,    0, 12));
    vt.push_back(v(1,1,0,0, 0,    0,     0,   0, 0,    0, 0));  // reset w/ stall
    vt.push_back(v(0,0,0,0, 0,    0,     1,   1, 0,    0, 1));
    vt.push_back(v(0,0,1,0, 4094, 5,     4,   0, 0,    0, 1));  // branch wrap
    vt.push_back(v(0,0,0,0, 0,    0,     5,   1, 4,    0, 2));

    foreach (vt[i]) begin
      cycle(vt[i].rst, vt[i].stl, vt[i].rv, vt[i].rj, vt[i].rpc, vt[i].rimm);
      chk($sformatf("v%0d imem_address", i), int'(imem_address), vt[i].e_addr);
      chk($sformatf("v%0d if_id_valid", i), int'(if_id_valid), int'(vt[i].e_vld));
      chk($sformatf("v%0d if_id_pc", i), int'(if_id_pc), vt[i].e_ifpc);
      chk($sformatf("v%0d if_id_instruction", i), int'(if_id_instruction),
          vt[i].e_vld ? word_at(vt[i].e_ifpc) : 0);
      chk($sformatf("v%0d halted", i), int'(halted), int'(vt[i].e_halt));
      chk($sformatf("v%0d fetch_count", i), int'(fetch_count), vt[i].e_cnt);
    end

    // Randomized phase: fresh memory with sparse halt words.
    for (int a = 0; a < 4096; a++)
      mem[a] = ($urandom_range(0, 11) == 0) ? '0 : IW'($urandom_range(1, (1 << IW) - 1));
    cycle(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 800; c++) begin
      bit rst, stl, rv, rj;
      int rpc, rimm;
      rst  = ($urandom_range(0, 99) == 0);
      stl  = ($urandom_range(0, 4) == 0);
      rv   = ($urandom_range(0, 9) == 0);
      rj   = $urandom_range(0, 1) == 1;
      rpc  = $urandom_range(0, 4095);
      rimm = $urandom_range(0, 4095);
      cycle(rst, stl, rv, rj, rpc, rimm);
      model_step(rst, stl, rv, rj, rpc, rimm);
      chk($sformatf("r%0d imem_address", c), int'(imem_address), m_pc);
      chk($sformatf("r%0d if_id_valid", c), int'(if_id_valid), int'(m_vld));
      chk($sformatf("r%0d if_id_pc", c), int'(if_id_pc), m_ifpc);
      chk($sformatf("r%0d if_id_instruction", c), int'(if_id_instruction), m_instr);
      chk($sformatf("r%0d halted", c), int'(halted), int'(m_halt));
      chk($sformatf("r%0d fetch_count", c), int'(fetch_count), m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
